// File: rtl/proc_mem_arbiter.sv
// Two-to-one memory request arbiter with round-robin grant and an in-order
// tag FIFO that routes each memory response back to the port that issued it.
module proc_mem_arbiter #(
  parameter int p_max_inflight = 2,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic                    req0_type,
  input  logic [p_addr_nbits-1:0] req0_addr,
  input  logic [p_data_nbits-1:0] req0_data,
  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic                    req1_type,
  input  logic [p_addr_nbits-1:0] req1_addr,
  input  logic [p_data_nbits-1:0] req1_data,
  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  output logic                    mem_req_type,
  output logic [p_addr_nbits-1:0] mem_req_addr,
  output logic [p_data_nbits-1:0] mem_req_data,
  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,
  input  logic                    mem_resp_type,
  input  logic [p_data_nbits-1:0] mem_resp_data,
  output logic                    resp0_val,
  input  logic                    resp0_rdy,
  output logic                    resp0_type,
  output logic [p_data_nbits-1:0] resp0_data,
  output logic                    resp1_val,
  input  logic                    resp1_rdy,
  output logic                    resp1_type,
  output logic [p_data_nbits-1:0] resp1_data,
  output logic [3:0]              inflight_count,
  output logic                    err
);

  localparam logic [3:0] MAX_CNT  = 4'(p_max_inflight);
  localparam logic [2:0] LAST_PTR = 3'(p_max_inflight - 1);

  // Priority pointer: 0 favours port 0, 1 favours port 1.
  logic       prio;
  // Tag storage is a packed vector so a 3-bit pointer indexes it exactly.
  logic [7:0] tags;
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] count;
  logic       err_q;

  logic full;
  logic empty;
  logic grant0;
  logic grant1;
  logic head;
  logic push;
  logic pop;

  function automatic logic [2:0] next_ptr(input logic [2:0] ptr);
    return (ptr == LAST_PTR) ? 3'd0 : ptr + 3'd1;
  endfunction

  assign full  = (count == MAX_CNT);
  assign empty = (count == 4'd0);
  assign head  = tags[rd_ptr];

  // Round-robin grant; independent of mem_req_rdy so the choice is stable
  // while the memory stalls.
  assign grant1 = req1_val & (~req0_val | prio);
  assign grant0 = req0_val & ~grant1;

  assign mem_req_val  = ~reset & (req0_val | req1_val) & ~full;
  assign req0_rdy     = ~reset & grant0 & mem_req_rdy & ~full;
  assign req1_rdy     = ~reset & grant1 & mem_req_rdy & ~full;
  assign mem_req_type = grant1 ? req1_type : req0_type;
  assign mem_req_addr = grant1 ? req1_addr : req0_addr;
  assign mem_req_data = grant1 ? req1_data : req0_data;

  // Responses go to the owner recorded at the FIFO head; an empty FIFO
  // refuses every response so nothing is routed to a stale owner.
  assign resp0_val    = ~reset & ~empty & ~head & mem_resp_val;
  assign resp1_val    = ~reset & ~empty &  head & mem_resp_val;
  assign mem_resp_rdy = ~reset & ~empty & (head ? resp1_rdy : resp0_rdy);
  assign resp0_type   = mem_resp_type;
  assign resp0_data   = mem_resp_data;
  assign resp1_type   = mem_resp_type;
  assign resp1_data   = mem_resp_data;

  assign push = mem_req_val & mem_req_rdy;
  assign pop  = mem_resp_val & mem_resp_rdy;

  assign inflight_count = count;
  assign err            = err_q;

  // Control state: occupancy, FIFO pointers, priority pointer, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 4'd0;
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      prio   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
        prio   <= ~grant1;
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (mem_resp_val && empty) begin
        err_q <= 1'b1;
      end
    end
  end

  // Tag storage: owner id of each accepted request, written at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      tags[wr_ptr] <= grant1;
    end
  end

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Directed bench for proc_mem_arbiter with hand-computed expectations.
module tb_proc_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_val, req0_rdy, req0_type;
  logic [31:0] req0_addr, req0_data;
  logic        req1_val, req1_rdy, req1_type;
  logic [31:0] req1_addr, req1_data;
  logic        mem_req_val, mem_req_rdy, mem_req_type;
  logic [31:0] mem_req_addr, mem_req_data;
  logic        mem_resp_val, mem_resp_rdy, mem_resp_type;
  logic [31:0] mem_resp_data;
  logic        resp0_val, resp0_rdy, resp0_type;
  logic [31:0] resp0_data;
  logic        resp1_val, resp1_rdy, resp1_type;
  logic [31:0] resp1_data;
  logic [3:0]  inflight_count;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  proc_mem_arbiter #(
    .p_max_inflight(2),
    .p_addr_nbits(32),
    .p_data_nbits(32)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_type(req0_type),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_type(req1_type),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_req_type(mem_req_type), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .mem_resp_type(mem_resp_type), .mem_resp_data(mem_resp_data),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_type(resp0_type),
    .resp0_data(resp0_data),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_type(resp1_type),
    .resp1_data(resp1_data),
    .inflight_count(inflight_count), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_val = 0; req0_type = 0; req0_addr = 32'h200;  req0_data = 0;
    req1_val = 0; req1_type = 1; req1_addr = 32'h1000; req1_data = 32'hAA;
    mem_req_rdy = 1; mem_resp_val = 0; mem_resp_type = 0; mem_resp_data = 0;
    resp0_rdy = 1; resp1_rdy = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1;
    step();
    req0_val = 1;
    #1;
    chk("rst_mem_req_val", mem_req_val, 0);
    chk("rst_req0_rdy", req0_rdy, 0);
    chk("rst_mem_resp_rdy", mem_resp_rdy, 0);
    step();
    chk("rst_count", inflight_count, 0);
    chk("rst_err", err, 0);

    // 1: single port-0 read, response two cycles later.
    idle();
    reset = 0;
    req0_val = 1;
    #1;
    chk("t1_mem_req_val", mem_req_val, 1);
    chk("t1_addr", mem_req_addr, 32'h200);
    chk("t1_req0_rdy", req0_rdy, 1);
    chk("t1_req1_rdy", req1_rdy, 0);
    step();
    req0_val = 0;
    #1;
    chk("t1_count1", inflight_count, 1);
    chk("t1_mem_req_val_off", mem_req_val, 0);
    chk("t1_no_resp_yet", resp0_val, 0);
    step();
    mem_resp_val = 1; mem_resp_data = 32'h13;
    #1;
    chk("t1_resp0_val", resp0_val, 1);
    chk("t1_resp0_data", resp0_data, 32'h13);
    chk("t1_resp1_val", resp1_val, 0);
    chk("t1_mem_resp_rdy", mem_resp_rdy, 1);
    step();
    mem_resp_val = 0;
    chk("t1_count0", inflight_count, 0);
    chk("t1_err", err, 0);

    // 2: both ports continuously, grants alternate from port 0.
    do_reset();
    req0_val = 1; req1_val = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        req0_val = 0; req1_val = 0;
      end
      mem_resp_val = (k >= 1);
      mem_resp_data = 32'h100 + k;
      #1;
      if (k < 4) begin
        chk($sformatf("t2_addr%0d", k), mem_req_addr, (k % 2) ? 32'h1000 : 32'h200);
        chk($sformatf("t2_type%0d", k), mem_req_type, k % 2);
        chk($sformatf("t2_req0_rdy%0d", k), req0_rdy, (k % 2) == 0);
        chk($sformatf("t2_req1_rdy%0d", k), req1_rdy, (k % 2) == 1);
      end
      if (k >= 1) begin
        chk($sformatf("t2_resp0_val%0d", k), resp0_val, ((k - 1) % 2) == 0);
        chk($sformatf("t2_resp1_val%0d", k), resp1_val, ((k - 1) % 2) == 1);
        chk($sformatf("t2_resp_data%0d", k), ((k - 1) % 2) ? resp1_data : resp0_data, 32'h100 + k);
      end
      step();
    end
    mem_resp_val = 0;
    chk("t2_count_end", inflight_count, 0);

    // 3: fill to p_max_inflight with responses withheld.
    req0_val = 1;
    #1;
    chk("t3_acc0", req0_rdy, 1);
    step();
    chk("t3_acc1", req0_rdy, 1);
    step();
    chk("t3_full_count", inflight_count, 2);
    chk("t3_full_val", mem_req_val, 0);
    chk("t3_full_rdy", req0_rdy, 0);
    step();
    mem_resp_val = 1; mem_resp_data = 32'h55;
    #1;
    chk("t3_pop_same_cycle_blocked", mem_req_val, 0);
    chk("t3_pop_resp0", resp0_val, 1);
    step();
    mem_resp_val = 0;
    #1;
    chk("t3_count_after_pop", inflight_count, 1);
    chk("t3_next_acc_val", mem_req_val, 1);
    chk("t3_next_acc_rdy", req0_rdy, 1);
    step();
    req0_val = 0;
    chk("t3_count_refill", inflight_count, 2);
    mem_resp_val = 1;
    step();
    step();
    mem_resp_val = 0;
    chk("t3_drained", inflight_count, 0);

    // 4: owners [1,0] outstanding, port 1 stalls its response.
    req1_val = 1;
    #1;
    chk("t4_grant1", req1_rdy, 1);
    step();
    req1_val = 0; req0_val = 1;
    #1;
    chk("t4_grant0", req0_rdy, 1);
    step();
    req0_val = 0;
    resp1_rdy = 0; mem_resp_val = 1; mem_resp_data = 32'h77;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("t4_stall_rdy%0d", s), mem_resp_rdy, 0);
      chk($sformatf("t4_stall_r0%0d", s), resp0_val, 0);
      chk($sformatf("t4_stall_r1%0d", s), resp1_val, 1);
      step();
    end
    chk("t4_stall_count", inflight_count, 2);
    resp1_rdy = 1;
    #1;
    chk("t4_first_r1", resp1_val, 1);
    chk("t4_first_rdy", mem_resp_rdy, 1);
    step();
    chk("t4_second_r0", resp0_val, 1);
    chk("t4_second_r1", resp1_val, 0);
    step();
    mem_resp_val = 0;
    chk("t4_count_end", inflight_count, 0);

    // 5: spurious response on an empty FIFO.
    do_reset();
    mem_resp_val = 1;
    #1;
    chk("t5_resp_rdy", mem_resp_rdy, 0);
    chk("t5_r0", resp0_val, 0);
    chk("t5_r1", resp1_val, 0);
    step();
    mem_resp_val = 0;
    chk("t5_err_set", err, 1);
    step();
    chk("t5_err_held", err, 1);
    do_reset();
    chk("t5_err_cleared", err, 0);

    // 6: reset with two requests in flight; pointer back to port 0.
    req0_val = 1;
    step();
    step();
    chk("t6_pre_count", inflight_count, 2);
    req1_val = 1;
    reset = 1;
    #1;
    chk("t6_rst_val", mem_req_val, 0);
    step();
    reset = 0;
    req0_val = 0; req1_val = 0;
    mem_resp_val = 1;
    #1;
    chk("t6_count_cleared", inflight_count, 0);
    chk("t6_spurious_rdy", mem_resp_rdy, 0);
    step();
    mem_resp_val = 0;
    chk("t6_spurious_err", err, 1);
    req0_val = 1; req1_val = 1;
    #1;
    chk("t6_grant_port0_addr", mem_req_addr, 32'h200);
    chk("t6_grant_port0_rdy", req0_rdy, 1);
    chk("t6_port1_not_rdy", req1_rdy, 0);
    step();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_mem_arbiter.md
Name: proc_mem_arbiter

Overview:
Two-to-one memory request arbiter that shares one memory port between the processor's instruction-fetch requester (port 0) and data-memory requester (port 1). Arbitration is round-robin. A tag FIFO records the owner of each in-flight request, and in-order responses are routed back to their owner. The block sits between the pipelined processor's imem/dmem ports and a single-ported cache or test memory.

Parameters:
p_max_inflight, 2, maximum outstanding requests; tag FIFO depth (1..8).
p_addr_nbits, 32, request address width.
p_data_nbits, 32, request/response data width.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req0_val  in  1  port 0 (imem) request valid
req0_rdy  out  1  port 0 request ready
req0_type  in  1  port 0 request type: 0 read, 1 write
req0_addr  in  p_addr_nbits  port 0 request address
req0_data  in  p_data_nbits  port 0 request write data
req1_val, req1_rdy, req1_type, req1_addr, req1_data  as port 0, for port 1 (dmem)
mem_req_val  out  1  shared memory request valid
mem_req_rdy  in  1  shared memory request ready
mem_req_type/addr/data  out  1/p_addr_nbits/p_data_nbits  granted request fields
mem_resp_val  in  1  memory response valid
mem_resp_rdy  out  1  memory response ready
mem_resp_type  in  1  response type
mem_resp_data  in  p_data_nbits  response data
resp0_val, resp0_rdy(in), resp0_type, resp0_data  port 0 response
resp1_val, resp1_rdy(in), resp1_type, resp1_data  port 1 response
inflight_count  out  4  current tag FIFO occupancy
err  out  1  sticky protocol-error flag

Behaviour:
- Reset: FIFO empty; inflight_count=0; priority pointer=0 (port 0 favoured); err=0.
  - All val/rdy outputs are 0 during reset and in the first cycle after reset unless inputs qualify.
- full = (inflight_count == p_max_inflight).
- Grant (combinational):
  - If only one reqN_val is set, that port wins.
  - If both are set, the port named by the priority pointer wins.
  - The grant does not depend on mem_req_rdy.
- mem_req_val = (req0_val | req1_val) & !full.
- mem_req fields = granted port's fields. With no request pending, port 0's fields are driven.
- reqN_rdy = grantN & mem_req_rdy & !full. The non-granted port's rdy is 0.
- Request transfer (mem_req_val & mem_req_rdy):
  - The granted port id is pushed into the FIFO tail.
  - The pointer moves to the other port. With no transfer, the pointer holds.
- full blocks a push even if a pop occurs in the same cycle. This is a conservative rule.
- Response routing, FIFO non-empty, head = h:
  - resp_h_val = mem_resp_val; resp_(1-h)_val = 0.
  - mem_resp_rdy = resp_h_rdy.
  - resp type/data are driven to both ports; only the valid port consumes them.
- Response transfer (mem_resp_val & mem_resp_rdy) pops the head.
- FIFO empty:
  - mem_resp_rdy = 0 and both resp_val = 0.
  - If mem_resp_val = 1 while empty, err is set to 1 and stays set until reset.
- Simultaneous push and pop (not full): occupancy unchanged; pointers advance; ordering preserved.
- Zero-latency memory: a request and its response may not complete in the same cycle. A push becomes the head no earlier than the next cycle.
- inflight_count: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds p_max_inflight or goes below 0.
- FIFO pointers wrap modulo p_max_inflight.
- Reset mid-operation: all in-flight tags are discarded next cycle. Responses that arrive afterwards are treated as spurious and set err.
- No combinational path from mem_resp_val to any req*_rdy, or from req*_val to mem_resp_rdy.

Test Plan:
1. Port 0 read addr 0x200, mem_req_rdy=1, memory returns data 0x00000013 two cycles later -> mem_req_addr=0x200 for one cycle; resp0_val=1 with 0x00000013; resp1_val stays 0; inflight_count goes 0->1->0.
2. Both ports valid continuously (0x200 reads on port 0, 0x1000 writes on port 1), mem_req_rdy=1, responses returned promptly -> grants alternate 0,1,0,1 starting with port 0; responses route to ports in the same order.
3. p_max_inflight=2, memory withholds responses -> exactly two requests accepted; mem_req_val=0 and req*_rdy=0 thereafter. One response is returned -> the next request is accepted the following cycle, not the same cycle.
4. Interleaved owners [1,0] outstanding with resp1_rdy=0 for 3 cycles -> mem_resp_rdy=0 and resp0_val=0 during the stall; on resp1_rdy=1 port 1 receives first, then port 0.
5. mem_resp_val=1 with FIFO empty after reset -> mem_resp_rdy=0, no resp valid, err=1 and held. Assert reset -> err=0.
6. Reset asserted with 2 requests in flight -> inflight_count=0 and pointer=0 next cycle; both ports requesting -> port 0 granted first.
